// File: rtl/exec_stage.sv
// Y86-64 execute stage: ALU operand select, Kogge-Stone adder, condition evaluation,
// condition-code register and a one-entry registered output with valid/ready handshake.

module addition (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c0,
    output logic [63:0] sum
);
    function automatic logic [31:0] ksa32(input logic [31:0] x, input logic [31:0] y,
                                          input logic cin);
        logic [31:0] g, p, g_n, p_n, half, carry;
        g    = x & y;
        p    = x ^ y;
        half = p;
        for (int d = 1; d < 32; d = d * 2) begin
            g_n = g;
            p_n = p;
            for (int i = d; i < 32; i++) begin
                g_n[i] = g[i] | (p[i] & g[i-d]);
                p_n[i] = p[i] & p[i-d];
            end
            g = g_n;
            p = p_n;
        end
        carry = {g[30:0] | (p[30:0] & {31{cin}}), cin};
        return half ^ carry;
    endfunction

    logic [31:0] s_lo, s_hi;
    logic        c_lo;

    assign s_lo = ksa32(a[31:0], b[31:0], c0);
    // Carry out of the low half, recovered from its sum bit 31.
    assign c_lo = (a[31] & b[31]) | ((a[31] ^ b[31]) & ~s_lo[31]);
    assign s_hi = ksa32(a[63:32], b[63:32], c_lo);
    assign sum  = {s_hi, s_lo};
endmodule

module exec_stage #(
    parameter logic [2:0] CC_RST = 3'b100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    input  logic        set_cc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valE,
    output logic        cnd,
    output logic [2:0]  cc,
    output logic        halted,
    output logic        err
);
    logic        out_valid_q, cnd_q, err_q, halted_q;
    logic [63:0] vale_q;
    logic [2:0]  cc_q;

    logic [63:0] alu_a, alu_b, add_a, sum, vale_d;
    logic        is_op, is_cond, is_sub, invalid, accept, of_d, cnd_raw, cnd_d, cc_we;
    logic        zf, sf, of;

    assign is_op   = (icode == 4'h6);
    assign is_cond = (icode == 4'h2) || (icode == 4'h7);
    assign is_sub  = is_op && (ifun == 4'h1);
    assign invalid = (icode > 4'hB) || (is_op && ifun > 4'h3) || (is_cond && ifun > 4'h6);

    assign in_ready = !halted_q && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign cc_we    = accept && is_op && !invalid && set_cc;

    always_comb begin
        case (icode)
            4'h2, 4'h6:       alu_a = valA;
            4'h3, 4'h4, 4'h5: alu_a = valC;
            4'h8, 4'hA:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            4'h9, 4'hB:       alu_a = 64'd8;
            default:          alu_a = '0;
        endcase
        alu_b = (icode == 4'h2 || icode == 4'h3) ? '0 : valB;
    end

    // Subtraction reuses the adder as B + ~A + 1.
    assign add_a = is_sub ? ~alu_a : alu_a;

    addition u_add (
        .a  (add_a),
        .b  (alu_b),
        .c0 (is_sub),
        .sum(sum)
    );

    always_comb begin
        vale_d = sum;
        of_d   = 1'b0;
        if (is_op) begin
            case (ifun)
                4'h0:    of_d = (alu_a[63] == alu_b[63]) && (sum[63] != alu_a[63]);
                4'h1:    of_d = (alu_a[63] != alu_b[63]) && (sum[63] != alu_b[63]);
                4'h2:    vale_d = alu_b & alu_a;
                4'h3:    vale_d = alu_b ^ alu_a;
                default: vale_d = sum;
            endcase
        end
        if (invalid || icode == 4'h0) vale_d = '0;
    end

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    always_comb begin
        case (ifun)
            4'h0:    cnd_raw = 1'b1;
            4'h1:    cnd_raw = (sf ^ of) | zf;
            4'h2:    cnd_raw = sf ^ of;
            4'h3:    cnd_raw = zf;
            4'h4:    cnd_raw = !zf;
            4'h5:    cnd_raw = !(sf ^ of);
            4'h6:    cnd_raw = !(sf ^ of) && !zf;
            default: cnd_raw = 1'b0;
        endcase
        cnd_d = is_cond && !invalid && cnd_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            vale_q      <= '0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            halted_q    <= 1'b0;
            cc_q        <= CC_RST;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                vale_q      <= vale_d;
                cnd_q       <= cnd_d;
                err_q       <= invalid;
                if (invalid || icode == 4'h0) halted_q <= 1'b1;
                if (cc_we) cc_q <= {vale_d == 64'd0, vale_d[63], of_d};
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign valE      = vale_q;
    assign cnd       = cnd_q;
    assign err       = err_q;
    assign halted    = halted_q;
    assign cc        = cc_q;
endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: vector table, directed corner sequences and
// randomized traffic against an arithmetic reference model.

module tb_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, set_cc, out_valid, out_ready, cnd, halted, err;
    logic [3:0]  icode, ifun;
    logic [63:0] valA, valB, valC, valE;
    logic [2:0]  cc;

    int total = 0;
    int bad   = 0;

    exec_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .set_cc(set_cc), .out_valid(out_valid), .out_ready(out_ready),
        .valE(valE), .cnd(cnd), .cc(cc), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ic, fn;
        logic [63:0] a, b, c, e;
        logic        cd;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic sc);
        icode = ic; ifun = fn; valA = a; valB = b; valC = c; set_cc = sc; in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0; set_cc = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference: result from the instruction semantics, overflow from 65-bit signed math.
    function automatic void model(input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] c, input logic sc, input logic [2:0] ccin,
                                  output logic [63:0] e, output logic cd, output logic er,
                                  output logic hl, output logic [2:0] ccout);
        logic [64:0] w;
        logic lt;
        e = '0; cd = 1'b0; er = 1'b0; hl = 1'b0; ccout = ccin; w = '0;
        case (ic)
            4'h0:       hl = 1'b1;
            4'h1, 4'h7: e = b;
            4'h2:       e = a;
            4'h3:       e = c;
            4'h4, 4'h5: e = c + b;
            4'h8, 4'hA: e = b - 64'd8;
            4'h9, 4'hB: e = b + 64'd8;
            4'h6: begin
                if (fn > 4'h3) er = 1'b1;
                else begin
                    case (fn)
                        4'h0: begin e = b + a; w = {b[63], b} + {a[63], a}; end
                        4'h1: begin e = b - a; w = {b[63], b} - {a[63], a}; end
                        4'h2: begin e = b & a; w = {e[63], e}; end
                        default: begin e = b ^ a; w = {e[63], e}; end
                    endcase
                    if (sc) ccout = {e == 64'd0, e[63], w[64] != w[63]};
                end
            end
            default: er = 1'b1;
        endcase
        if (ic == 4'h2 || ic == 4'h7) begin
            if (fn > 4'h6) er = 1'b1;
            else begin
                lt = ccin[1] ^ ccin[0];
                case (fn)
                    4'h0: cd = 1'b1;
                    4'h1: cd = lt | ccin[2];
                    4'h2: cd = lt;
                    4'h3: cd = ccin[2];
                    4'h4: cd = !ccin[2];
                    4'h5: cd = !lt;
                    default: cd = !lt && !ccin[2];
                endcase
            end
        end
        if (er) begin e = '0; cd = 1'b0; hl = 1'b1; ccout = ccin; end
    endfunction

    logic [63:0] m_e, n_e;
    logic        m_ov, m_cd, m_er, m_hl, n_cd, n_er, n_hl, exp_rdy;
    logic [2:0]  m_cc, n_cc;
    logic [3:0]  bad_ic[5];
    logic [3:0]  bad_fn[5];

    initial begin
        tbl[0]  = '{4'h6, 4'h0, 64'h3, 64'h4, 64'h0, 64'h7, 1'b0};
        tbl[1]  = '{4'h6, 4'h1, 64'h5, 64'h3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        tbl[2]  = '{4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'h0, 64'hF000, 1'b0};
        tbl[3]  = '{4'h6, 4'h3, 64'hF0F0, 64'hFF00, 64'h0, 64'h0FF0, 1'b0};
        tbl[4]  = '{4'h6, 4'h0, 64'hFFFF_FFFF, 64'h1, 64'h0, 64'h1_0000_0000, 1'b0};
        tbl[5]  = '{4'h2, 4'h0, 64'h55, 64'h99, 64'h0, 64'h55, 1'b1};
        tbl[6]  = '{4'h2, 4'h2, 64'h11, 64'h99, 64'h0, 64'h11, 1'b0};
        tbl[7]  = '{4'h3, 4'h0, 64'h0, 64'h77, 64'h1234, 64'h1234, 1'b0};
        tbl[8]  = '{4'h4, 4'h0, 64'h0, 64'h100, 64'h10, 64'h110, 1'b0};
        tbl[9]  = '{4'h5, 4'h0, 64'h0, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 64'hF0, 1'b0};
        tbl[10] = '{4'h7, 4'h3, 64'h0, 64'hABC, 64'h0, 64'hABC, 1'b1};
        tbl[11] = '{4'h7, 4'h4, 64'h0, 64'hABC, 64'h0, 64'hABC, 1'b0};
        tbl[12] = '{4'h7, 4'h1, 64'h0, 64'h1, 64'h0, 64'h1, 1'b1};
        tbl[13] = '{4'h7, 4'h5, 64'h0, 64'h1, 64'h0, 64'h1, 1'b1};
        tbl[14] = '{4'h7, 4'h6, 64'h0, 64'h1, 64'h0, 64'h1, 1'b0};
        tbl[15] = '{4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 64'h1F8, 1'b0};
        tbl[16] = '{4'h9, 4'h0, 64'h0, 64'h200, 64'h0, 64'h208, 1'b0};
        tbl[17] = '{4'h1, 4'h0, 64'h0, 64'h42, 64'h0, 64'h42, 1'b0};
        tbl[18] = '{4'hA, 4'h0, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        tbl[19] = '{4'hB, 4'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0; set_cc = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_valE", valE, 64'h0);
        chk("rst_cnd", 64'(cnd), 64'(1'b0));
        chk("rst_err", 64'(err), 64'(1'b0));
        chk("rst_halted", 64'(halted), 64'(1'b0));
        chk("rst_cc", 64'(cc), 64'(3'b100));
        do_reset();
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));

        // Table: set_cc=0 throughout, so CC stays at its reset value {1,0,0}.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].ic, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].c, 1'b0);
            #1 chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(1'b1));
            tick();
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(1'b1));
            chk($sformatf("tbl%0d_valE", i), valE, tbl[i].e);
            chk($sformatf("tbl%0d_cnd", i), 64'(cnd), 64'(tbl[i].cd));
            chk($sformatf("tbl%0d_err", i), 64'(err), 64'(1'b0));
            chk($sformatf("tbl%0d_cc", i), 64'(cc), 64'(3'b100));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'(1'b0));

        drive(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("add_ovf_valid", 64'(out_valid), 64'(1'b1));
        chk("add_ovf_valE", valE, 64'h8000_0000_0000_0000);
        chk("add_ovf_cc", 64'(cc), 64'(3'b011));
        drive(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 1'b1);
        tick();
        chk("sub_eq_valE", valE, 64'h0);
        chk("sub_eq_cc", 64'(cc), 64'(3'b100));
        drive(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 1'b0);
        tick();
        chk("je_taken", 64'(cnd), 64'(1'b1));
        drive(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        tick();
        drive(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 1'b0);
        tick();
        chk("sub_nocc_cc", 64'(cc), 64'(3'b011));
        drive(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 1'b0);
        tick();
        chk("je_not_taken", 64'(cnd), 64'(1'b0));

        drive(4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 1'b0);
        tick();
        chk("push_valE", valE, 64'hF8);
        drive(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 1'b0);
        tick();
        chk("pop_valE", valE, 64'h108);
        chk("pop_valid", 64'(out_valid), 64'(1'b1));
        drive(4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 1'b0);
        tick();
        chk("irmov_valE", valE, 64'h1234);
        chk("irmov_valid", 64'(out_valid), 64'(1'b1));

        drive(4'h6, 4'h0, 64'h2, 64'h3, 64'h0, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(4'h3, 4'h0, 64'h0, 64'h0, 64'h99, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'(1'b0));
            chk($sformatf("stall%0d_valE", k), valE, 64'h5);
            chk($sformatf("stall%0d_valid", k), 64'(out_valid), 64'(1'b1));
            tick();
        end
        out_ready = 1'b1;
        #1 chk("release_in_ready", 64'(in_ready), 64'(1'b1));
        tick();
        in_valid = 1'b0;
        chk("release_valE", valE, 64'h99);
        chk("release_valid", 64'(out_valid), 64'(1'b1));
        tick();
        chk("release_drain", 64'(out_valid), 64'(1'b0));

        drive(4'h6, 4'h3, 64'hFF, 64'hFF, 64'h0, 1'b1);
        tick();
        chk("xor_cc", 64'(cc), 64'(3'b100));
        drive(4'h2, 4'h1, 64'h1, 64'h2, 64'h0, 1'b0);
        tick();
        chk("cmovle_cnd", 64'(cnd), 64'(1'b1));
        drive(4'h2, 4'h6, 64'h1, 64'h2, 64'h0, 1'b0);
        tick();
        chk("cmovg_cnd", 64'(cnd), 64'(1'b0));

        drive(4'h0, 4'h0, 64'h0, 64'h5, 64'h0, 1'b0);
        tick();
        drive(4'h1, 4'h0, 64'h0, 64'h5, 64'h0, 1'b0);
        #1;
        chk("halt_valE", valE, 64'h0);
        chk("halt_err", 64'(err), 64'(1'b0));
        chk("halt_halted", 64'(halted), 64'(1'b1));
        chk("halt_in_ready", 64'(in_ready), 64'(1'b0));
        tick();
        chk("halt_drain", 64'(out_valid), 64'(1'b0));
        chk("halt_sticky", 64'(halted), 64'(1'b1));

        do_reset();
        m_ov = 1'b0; m_e = '0; m_cd = 1'b0; m_er = 1'b0; m_cc = 3'b100; m_hl = 1'b0;
        for (int n = 0; n < 400; n++) begin
            icode = 4'($urandom_range(1, 11));
            if (icode == 4'h6) ifun = 4'($urandom_range(0, 3));
            else if (icode == 4'h2 || icode == 4'h7) ifun = 4'($urandom_range(0, 6));
            else ifun = 4'($urandom_range(0, 15));
            valB = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: valA = valB;
                1: valA = {$urandom_range(0, 1) == 0 ? 32'h7FFF_FFFF : 32'h8000_0000, $urandom};
                default: valA = {$urandom, $urandom};
            endcase
            valC = {$urandom, $urandom};
            set_cc = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !m_hl && (!m_ov || out_ready);
            chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
            model(icode, ifun, valA, valB, valC, set_cc, m_cc, n_e, n_cd, n_er, n_hl, n_cc);
            tick();
            if (in_valid && exp_rdy) begin
                m_ov = 1'b1; m_e = n_e; m_cd = n_cd; m_er = n_er; m_cc = n_cc;
                m_hl = m_hl | n_hl;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            chk("rnd_out_valid", 64'(out_valid), 64'(m_ov));
            chk("rnd_cc", 64'(cc), 64'(m_cc));
            if (m_ov) begin
                chk("rnd_valE", valE, m_e);
                chk("rnd_cnd", 64'(cnd), 64'(m_cd));
                chk("rnd_err", 64'(err), 64'(m_er));
            end
        end

        bad_ic[0] = 4'hC; bad_fn[0] = 4'h0;
        bad_ic[1] = 4'h6; bad_fn[1] = 4'h4;
        bad_ic[2] = 4'h7; bad_fn[2] = 4'h7;
        bad_ic[3] = 4'h2; bad_fn[3] = 4'h9;
        bad_ic[4] = 4'hF; bad_fn[4] = 4'h3;
        for (int j = 0; j < 5; j++) begin
            do_reset();
            drive(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
            tick();
            drive(bad_ic[j], bad_fn[j], 64'h3, 64'h4, 64'h5, 1'b1);
            tick();
            in_valid = 1'b0;
            out_ready = 1'b0;
            #1;
            chk($sformatf("inv%0d_err", j), 64'(err), 64'(1'b1));
            chk($sformatf("inv%0d_valE", j), valE, 64'h0);
            chk($sformatf("inv%0d_cnd", j), 64'(cnd), 64'(1'b0));
            chk($sformatf("inv%0d_halted", j), 64'(halted), 64'(1'b1));
            chk($sformatf("inv%0d_cc", j), 64'(cc), 64'(3'b011));
            chk($sformatf("inv%0d_in_ready", j), 64'(in_ready), 64'(1'b0));
            #1 rst_n = 1'b0;
            #1;
            chk($sformatf("arst%0d_valid", j), 64'(out_valid), 64'(1'b0));
            chk($sformatf("arst%0d_err", j), 64'(err), 64'(1'b0));
            chk($sformatf("arst%0d_halted", j), 64'(halted), 64'(1'b0));
            chk($sformatf("arst%0d_cc", j), 64'(cc), 64'(3'b100));
            chk($sformatf("arst%0d_valE", j), valE, 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the Y86-64 sequential datapath: takes decoded operands, selects ALU inputs, computes valE using the 64-bit `addition` adder (two 32-bit KSA halves), evaluates the branch/cmov condition, and owns the condition-code register. It sits between decode and memory stages. A valid/ready handshake and a one-entry registered output give a one-cycle latency with full throughput.

## Interface
- `CC_RST`, 3'b100, reset value of {ZF,SF,OF}.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `icode`  in  4  Y86 instruction code (0 HALT … 0xB POPQ).
- `ifun`  in  4  function / condition code.
- `valA`, `valB`, `valC`  in  64 each  decoded operands / immediate.
- `set_cc`  in  1  allow OPq to update CC (0 = suppress).
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  downstream accepts result.
- `valE`  out  64  ALU result.
- `cnd`  out  1  condition result for JXX/CMOVXX.
- `cc`  out  3  current {ZF,SF,OF}.
- `halted`  out  1  sticky: HALT or invalid instruction accepted.
- `err`  out  1  registered with result: instruction invalid.

## Operation
- Accept = `in_valid & in_ready`; `in_ready = !halted & (!out_valid | out_ready)`.
- ALU A: valA for 2 (RRMOVQ/CMOV) and 6 (OPq); valC for 3, 4, 5; -8 for 8 (CALL) and 0xA (PUSHQ); +8 for 9 (RET) and 0xB (POPQ); 0 otherwise.
- ALU B: 0 for 2 and 3; valB otherwise.
- Function: ADD for all icodes except 6. For OPq, ifun 0 = ADD (B+A), 1 = SUB (B-A), 2 = AND, 3 = XOR. ifun > 3 is invalid.
- ADD uses `addition` with c0=0, inputs (A,B). SUB uses the same adder with c0=1, inputs (~A,B). Results wrap modulo 2^64; carry-out is ignored.
- CC update happens only on accept of icode 6 with valid ifun and set_cc=1.
  - ZF = (valE==0); SF = valE[63].
  - OF for ADD = (A[63]==B[63]) & (valE[63]!=A[63]).
  - OF for SUB = (A[63]!=B[63]) & (valE[63]!=B[63]).
  - OF = 0 for AND and XOR.
- `cnd` uses the CC value before this instruction's update. It is computed for icode 2 and 7; it is 0 for all other icodes.
  - ifun 0 → 1.
  - ifun 1 (le) → (SF^OF)|ZF.
  - ifun 2 (l) → SF^OF.
  - ifun 3 (e) → ZF.
  - ifun 4 (ne) → !ZF.
  - ifun 5 (ge) → !(SF^OF).
  - ifun 6 (g) → !(SF^OF)&!ZF.
  - ifun > 6 → invalid.
- Invalid instruction (icode > 0xB, bad OPq ifun, bad cond ifun):
  - result is emitted with err=1, valE=0, cnd=0;
  - CC is not updated;
  - halted is set.
- HALT (icode 0): result emitted with valE=0, err=0; halted is set.
- NOP (icode 1): valE=0+valB is a don't-care, but it must be deterministic (= valB).

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid=0, valE=0, cnd=0, err=0, halted=0, cc=CC_RST;
  - in_ready=1 after reset is released.
- Latency: 1 cycle. An instruction accepted at edge N has its result visible with out_valid=1 after edge N.
- The output register holds valE/cnd/err stable while `out_valid & !out_ready`. While stalled, in_ready=0.
- Simultaneous events:
  - If out_ready and in_valid are both high with out_valid=1, the old result is consumed and the new one is loaded on the same edge (back-to-back, one per cycle).
  - out_valid falls only when the output is consumed with no new accept.
- CC is written on the accept edge. A CMOV/JXX accepted on the next cycle sees the new CC.
- After `halted` is set: in_ready=0 permanently. The pending result still drains normally. Only rst_n clears halted.
- If reset is asserted mid-transfer, the pending result is dropped; no partial CC update occurs.

## Test plan
- OPq ADD, valA=1, valB=0x7FFF_FFFF_FFFF_FFFF, set_cc=1 → valE=0x8000_0000_0000_0000, cc={0,1,1}, out_valid one cycle after accept.
- OPq SUB, valA=5, valB=5, then JXX ifun 3 → valE=0, cc={1,0,0}; jump cnd=1. Repeat with set_cc=0 → cc unchanged, jump cnd=0.
- Stream PUSHQ (valB=0x100), POPQ (valB=0x100), IRMOVQ (valC=0x1234) with out_ready=1 → valE 0xF8, 0x108, 0x1234 on consecutive cycles, no bubbles.
- Hold out_ready=0 for 3 cycles after one result → in_ready=0, valE stable. Release → next instruction is accepted on the same edge.
- icode 0xC → err=1, valE=0, halted=1, in_ready stays 0. Assert rst_n low asynchronously → all outputs at reset values immediately, cc=3'b100.
- CMOV ifun 1 after OPq XOR valA=valB=0xFF → cc={1,0,0}, cnd=1. A following CMOV ifun 6 → cnd=0.
